// File: rtl/prio_irq_ctrl_pkg.sv
// Shared constants and helpers for the priority interrupt controller.
package prio_irq_ctrl_pkg;

    localparam int unsigned DEFAULT_N = 8;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    // Ceiling log2, with a minimum result of 1 so index buses are never zero-width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/prio_irq_ctrl_find_hi.sv
// Combinational highest-set-bit finder with an any-bit-set flag.
module prio_find_hi
    import prio_irq_ctrl_pkg::*;
#(
    parameter int unsigned N    = DEFAULT_N,
    parameter int unsigned ID_W = clog2(N)
) (
    input  logic [N-1:0]    i_vec,
    output logic [ID_W-1:0] o_idx_c,
    output logic            o_any_c
);

    // Ascending scan; the last set bit seen is the highest one.
    always_comb begin
        o_idx_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (i_vec[i]) begin
                o_idx_c = ID_W'(i);
            end
        end
    end

    assign o_any_c = |i_vec;

endmodule

// File: rtl/prio_irq_ctrl.sv
// Registered priority interrupt controller: edge latching, masking,
// fixed or round-robin arbitration, valid/ack presentation handshake.
module prio_irq_ctrl
    import prio_irq_ctrl_pkg::*;
#(
    parameter int unsigned N    = DEFAULT_N,
    parameter int unsigned ID_W = clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic            rr_mode,
    input  logic            ack,
    output logic            valid,
    output logic [ID_W-1:0] id,
    output logic [N-1:0]    pending
);

    localparam int unsigned SUM_W = ID_W + 1;

    logic [N-1:0]    r_req_d;
    logic [N-1:0]    r_pending;
    logic [0:0]      r_state;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] r_last_grant;

    logic [N-1:0]    w_rise;
    logic [N-1:0]    w_cand;
    logic [N-1:0]    w_rot;
    logic [N-1:0]    w_clr;
    logic [ID_W-1:0] w_fix_idx;
    logic            w_fix_any;
    logic [ID_W-1:0] w_rot_idx;
    logic            w_rot_any;
    logic [ID_W-1:0] w_rr_idx;
    logic [ID_W-1:0] w_win_idx;
    logic            w_win_any;
    logic [0:0]      w_state_nxt;
    logic [ID_W-1:0] w_id_nxt;
    logic [ID_W-1:0] w_lg_nxt;

    assign w_rise = req & ~r_req_d;
    assign w_cand = r_pending & mask;

    // Rotate candidates right by last_grant so the top bit is last_grant-1.
    always_comb begin
        logic [SUM_W-1:0] k;
        w_rot = '0;
        k     = '0;
        for (int j = 0; j < int'(N); j++) begin
            k = SUM_W'(j) + {1'b0, r_last_grant};
            if (k >= SUM_W'(N)) begin
                k = k - SUM_W'(N);
            end
            w_rot[j] = w_cand[k[ID_W-1:0]];
        end
    end

    prio_find_hi #(.N(N), .ID_W(ID_W)) u_find_fix (
        .i_vec   (w_cand),
        .o_idx_c (w_fix_idx),
        .o_any_c (w_fix_any)
    );

    prio_find_hi #(.N(N), .ID_W(ID_W)) u_find_rr (
        .i_vec   (w_rot),
        .o_idx_c (w_rot_idx),
        .o_any_c (w_rot_any)
    );

    // Undo the rotation modulo N to recover the source index.
    always_comb begin
        logic [SUM_W-1:0] s;
        s = {1'b0, w_rot_idx} + {1'b0, r_last_grant};
        if (s >= SUM_W'(N)) begin
            s = s - SUM_W'(N);
        end
        w_rr_idx = s[ID_W-1:0];
    end

    assign w_win_idx = rr_mode ? w_rr_idx  : w_fix_idx;
    assign w_win_any = rr_mode ? w_rot_any : w_fix_any;

    // Next-state logic: latch a winner in IDLE, hold it until ack in PRESENT.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_lg_nxt    = r_last_grant;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_any) begin
                    w_state_nxt = ST_PRESENT;
                    w_id_nxt    = w_win_idx;
                end
            end
            ST_PRESENT: begin
                if (ack) begin
                    w_clr       = N'(1) << r_id;
                    w_lg_nxt    = r_id;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, presented id and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_id         <= '0;
            r_last_grant <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_id         <= w_id_nxt;
            r_last_grant <= w_lg_nxt;
        end
    end

    // Edge history and pending events; a new rise beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_d   <= '0;
            r_pending <= '0;
        end else begin
            r_req_d   <= req;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    assign valid   = (r_state == ST_PRESENT);
    assign id      = r_id;
    assign pending = r_pending;

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Self-checking bench for prio_irq_ctrl (N=8) with an expected-id scoreboard.
module tb_prio_irq_ctrl;

    localparam int unsigned N    = 8;
    localparam int unsigned ID_W = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            rr_mode;
    logic            ack;
    logic            valid;
    logic [ID_W-1:0] id;
    logic [N-1:0]    pending;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    logic prev_valid = 1'b0;

    prio_irq_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask    (mask),
        .rr_mode (rr_mode),
        .ack     (ack),
        .valid   (valid),
        .id      (id),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every new presentation must match the next expected id.
    always @(negedge clk) begin
        int e;
        if (valid === 1'b1 && prev_valid !== 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL present_unexpected: got id=%0d, required no presentation", id);
            end else begin
                e = exp_q.pop_front();
                if (id !== ID_W'(e)) begin
                    n_fail++;
                    $display("FAIL present_id: got id=%0d, required %0d", id, e);
                end
            end
        end
        prev_valid = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (valid === 1'b1) ok = 1'b1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        ack     = 1'b0;
        mask    = '1;
        rr_mode = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        ack     = 1'b0;
        mask    = '1;
        rr_mode = 1'b0;
        tick(2);
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_checks++;
        if (id !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d, required 0", id); end
        n_checks++;
        if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h, required 00", pending); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed();
        bit ok;
        exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2);
        req = 8'hA4;
        tick();
        n_checks++;
        if (pending !== 8'hA4 || valid !== 1'b0) begin
            n_fail++; $display("FAIL fixed_latch: got pending=%h valid=%b, required A4/0", pending, valid);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd7) begin
            n_fail++; $display("FAIL fixed_latency: got valid=%b id=%0d, required 1/7", valid, id);
        end
        ack_pulse();
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h24) begin
            n_fail++; $display("FAIL fixed_bubble: got valid=%b pending=%h, required 0/24", valid, pending);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd5) begin
            n_fail++; $display("FAIL fixed_second: got valid=%b id=%0d, required 1/5", valid, id);
        end
        ack_pulse();
        wait_valid(4, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fixed_third_timeout: got valid=%b, required 1", valid); end
        ack_pulse();
        tick(3);
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++; $display("FAIL fixed_drain: got valid=%b pending=%h, required 0/00", valid, pending);
        end
        req = '0;
        tick();
    endtask

    task automatic test_mask();
        mask = 8'h7F;
        exp_q.push_back(3); exp_q.push_back(7);
        req = 8'h88;
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd3 || pending !== 8'h88) begin
            n_fail++; $display("FAIL mask_select: got valid=%b id=%0d pending=%h, required 1/3/88", valid, id, pending);
        end
        mask = 8'h00;
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd3) begin
            n_fail++; $display("FAIL mask_no_withdraw: got valid=%b id=%0d, required 1/3", valid, id);
        end
        mask = 8'h7F;
        ack_pulse();
        tick(2);
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h80) begin
            n_fail++; $display("FAIL mask_blocked: got valid=%b pending=%h, required 0/80", valid, pending);
        end
        mask = 8'hFF;
        tick();
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd7) begin
            n_fail++; $display("FAIL mask_unmask: got valid=%b id=%0d, required 1/7", valid, id);
        end
        ack_pulse();
        req = '0;
        tick();
    endtask

    // 7 and 5 both pending at the same IDLE decision just after 7 was acked.
    task automatic test_rr(input bit mode);
        bit ok;
        logic [ID_W-1:0] want;
        do_reset();
        rr_mode = mode;
        exp_q.push_back(7);
        if (mode) begin exp_q.push_back(5); exp_q.push_back(7); end
        else      begin exp_q.push_back(7); exp_q.push_back(5); end
        req = 8'hA0;
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd7) begin
            n_fail++; $display("FAIL rr_first mode=%0d: got valid=%b id=%0d, required 1/7", mode, valid, id);
        end
        req = 8'h20;
        tick();
        req = 8'hA0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (pending !== 8'hA0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_repend mode=%0d: got pending=%h valid=%b, required A0/0", mode, pending, valid);
        end
        tick();
        want = mode ? 3'd5 : 3'd7;
        n_checks++;
        if (valid !== 1'b1 || id !== want) begin
            n_fail++; $display("FAIL rr_choice mode=%0d: got valid=%b id=%0d, required 1/%0d", mode, valid, id, want);
        end
        ack_pulse();
        wait_valid(4, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_last_timeout mode=%0d: got valid=%b, required 1", mode, valid); end
        ack_pulse();
        tick(2);
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++; $display("FAIL rr_drain mode=%0d: got valid=%b pending=%h, required 0/00", mode, valid, pending);
        end
        req = '0;
        tick();
    endtask

    task automatic test_set_wins();
        do_reset();
        exp_q.push_back(4); exp_q.push_back(4);
        req = 8'h10;
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd4) begin
            n_fail++; $display("FAIL setwins_first: got valid=%b id=%0d, required 1/4", valid, id);
        end
        req = '0;
        tick();
        req = 8'h10;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (pending[4] !== 1'b1 || valid !== 1'b0) begin
            n_fail++; $display("FAIL setwins_pending: got pending=%h valid=%b, required bit4=1/0", pending, valid);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd4) begin
            n_fail++; $display("FAIL setwins_again: got valid=%b id=%0d, required 1/4", valid, id);
        end
        ack_pulse();
        req = '0;
        tick();
        n_checks++;
        if (pending !== 8'h00) begin n_fail++; $display("FAIL setwins_clear: got pending=%h, required 00", pending); end
    endtask

    task automatic test_level_hold();
        int seen;
        exp_q.push_back(2); exp_q.push_back(2);
        req = 8'h04;
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd2) begin
            n_fail++; $display("FAIL level_first: got valid=%b id=%0d, required 1/2", valid, id);
        end
        ack_pulse();
        seen = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0 || pending !== 8'h00) begin
            n_fail++; $display("FAIL level_single: got %0d extra valid cycles pending=%h, required 0/00", seen, pending);
        end
        req = '0;
        tick();
        req = 8'h04;
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd2) begin
            n_fail++; $display("FAIL level_reraise: got valid=%b id=%0d, required 1/2", valid, id);
        end
        ack_pulse();
        req = '0;
        tick();
    endtask

    task automatic test_ack_idle();
        ack = 1'b1;
        tick(3);
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++; $display("FAIL ack_idle: got valid=%b pending=%h, required 0/00", valid, pending);
        end
        exp_q.push_back(1);
        req = 8'h02;
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd1) begin
            n_fail++; $display("FAIL ack_held_present: got valid=%b id=%0d, required 1/1", valid, id);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++; $display("FAIL ack_held_consume: got valid=%b pending=%h, required 0/00", valid, pending);
        end
        ack = 1'b0;
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(1);
        req = 8'h02;
        tick(2);
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got valid=%b, required 1", valid); end
        req = 8'h40;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_async: got valid=%b pending=%h, required 0/00", valid, pending);
        end
        tick();
        rst_n = 1'b1;
        exp_q.push_back(6);
        tick();
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h40) begin
            n_fail++; $display("FAIL rstmid_latch: got valid=%b pending=%h, required 0/40", valid, pending);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || id !== 3'd6) begin
            n_fail++; $display("FAIL rstmid_present: got valid=%b id=%0d, required 1/6", valid, id);
        end
        ack_pulse();
        req = '0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_mask();
        test_rr(1'b1);
        test_rr(1'b0);
        test_set_wins();
        test_level_hold();
        test_ack_idle();
        test_reset_mid();
        tick(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d unmatched expected ids, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
